// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision adder controller:
// FSM states, field widths and the extended-significand bit layout.
package fp16_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  localparam int EXP_WIDTH  = 5;
  localparam int FRAC_WIDTH = 10;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = 5'd31;

  // Extended word: carry | hidden 1 | frac | 4 guard bits
  localparam int CARRY_BIT  = 15;
  localparam int HIDDEN_BIT = 14;
  localparam int FRAC_MSB   = 13;
  localparam int FRAC_LSB   = 4;

  localparam logic [15:0] QNAN = 16'h7E00;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [FRAC_WIDTH-1:0] frac;
  } fp16_t;

  // Denormals flush to a zero significand.
  function automatic logic [15:0] ext_word(input fp16_t f);
    logic [15:0] w;
    w = '0;
    if (f.exp != '0) begin
      w[HIDDEN_BIT]        = 1'b1;
      w[FRAC_MSB:FRAC_LSB] = f.frac;
    end
    return w;
  endfunction

endpackage

// File: rtl/fp16_add_controller_lzc.sv
// Leading-zero count over a 15-bit significand (bits 14:0 of the extended word).
module leading_zero_counter (
  input  logic [14:0] data,
  output logic [3:0]  count
);
  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = 4'd15;
    for (int i = 0; i < 15; i++)
      if (data[i]) count = 4'(14 - i);
  end
endmodule

// File: rtl/fp16_add_controller.sv
// Multi-cycle fp16 adder sequencer; time-shares one external barrel shifter
// between exponent alignment and post-add normalization. Round toward zero.
module fp16_add_controller
  import fp16_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int AMOUNT_WIDTH = 8
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic [15:0]             a_in,
  input  logic [15:0]             b_in,
  input  logic                    in_valid_in,
  output logic                    in_ready_out,
  output logic [15:0]             sum_out,
  output logic                    out_valid_out,
  input  logic                    out_ready_in,
  output logic [WIDTH-1:0]        shift_data_out,
  output logic [AMOUNT_WIDTH-1:0] shift_amount_out,
  output logic                    shift_dir_out,
  input  logic [WIDTH-1:0]        shift_result_in
);

  state_t state, state_nx;

  fp16_t a_f, b_f, l_f, s_f;
  assign a_f = a_in;
  assign b_f = b_in;

  // Magnitude order: exponent first, then fraction == compare bits 14:0.
  always_comb begin
    if (a_in[14:0] >= b_in[14:0]) begin
      l_f = a_f; s_f = b_f;
    end else begin
      l_f = b_f; s_f = a_f;
    end
  end

  logic a_nan, b_nan, a_inf, b_inf, is_special;
  logic [15:0] special_nx;
  assign a_nan = (a_f.exp == EXP_MAX) && (a_f.frac != '0);
  assign b_nan = (b_f.exp == EXP_MAX) && (b_f.frac != '0);
  assign a_inf = (a_f.exp == EXP_MAX) && (a_f.frac == '0);
  assign b_inf = (b_f.exp == EXP_MAX) && (b_f.frac == '0);
  assign is_special = (a_f.exp == EXP_MAX) || (b_f.exp == EXP_MAX);
  assign special_nx = (a_nan || b_nan || (a_inf && b_inf && (a_f.sign != b_f.sign))) ? QNAN :
                      a_inf ? a_in : b_in;

  logic                 sign_l, sign_s, special;
  logic [EXP_WIDTH-1:0] exp_l, exp_s, exp_diff;
  logic [WIDTH-1:0]     word_l, word_s, aligned, sum_word;
  logic [15:0]          special_val, result;
  logic [3:0]           lz;
  logic                 sum_zero;
  logic signed [6:0]    norm_exp;

  assign exp_diff = exp_l - exp_s;
  assign sum_zero = (sum_word == '0);

  leading_zero_counter u_lzc (
    .data  (sum_word[14:0]),
    .count (lz)
  );

  // Signed so a deep cancellation can go below zero before the flush check.
  assign norm_exp = sum_word[CARRY_BIT] ? $signed({2'b00, exp_l}) + 7'sd1
                                        : $signed({2'b00, exp_l}) - $signed({3'b000, lz});

  always_comb begin
    result = '0;
    if (special)
      result = special_val;
    else if (sum_zero)
      result = '0;
    else if (norm_exp >= $signed({2'b00, EXP_MAX}))
      result = {sign_l, EXP_MAX, {FRAC_WIDTH{1'b0}}};
    else if (norm_exp <= 7'sd0)
      result = {sign_l, 15'h0};
    else
      result = {sign_l, norm_exp[EXP_WIDTH-1:0], shift_result_in[FRAC_MSB:FRAC_LSB]};
  end

  always_comb begin
    state_nx         = state;
    in_ready_out     = 1'b0;
    out_valid_out    = 1'b0;
    shift_data_out   = '0;
    shift_amount_out = '0;
    shift_dir_out    = 1'b0;
    case (state)
      IDLE: begin
        in_ready_out = 1'b1;
        if (in_valid_in) state_nx = ALIGN;
      end
      ALIGN: begin
        shift_data_out   = word_s;
        shift_amount_out = AMOUNT_WIDTH'(exp_diff);
        shift_dir_out    = 1'b1;
        state_nx         = ADD;
      end
      ADD: state_nx = NORM;
      NORM: begin
        if (sum_word[CARRY_BIT]) begin
          shift_data_out   = sum_word;
          shift_amount_out = AMOUNT_WIDTH'(1);
          shift_dir_out    = 1'b1;
        end else if (!sum_zero) begin
          shift_data_out   = sum_word;
          shift_amount_out = AMOUNT_WIDTH'(lz);
        end
        state_nx = DONE;
      end
      DONE: begin
        out_valid_out = 1'b1;
        if (out_ready_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state       <= IDLE;
      sum_out     <= '0;
      sign_l      <= 1'b0;
      sign_s      <= 1'b0;
      exp_l       <= '0;
      exp_s       <= '0;
      word_l      <= '0;
      word_s      <= '0;
      aligned     <= '0;
      sum_word    <= '0;
      special     <= 1'b0;
      special_val <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid_in) begin
          sign_l      <= l_f.sign;
          sign_s      <= s_f.sign;
          exp_l       <= l_f.exp;
          exp_s       <= s_f.exp;
          word_l      <= ext_word(l_f);
          word_s      <= ext_word(s_f);
          special     <= is_special;
          special_val <= special_nx;
        end
        ALIGN: aligned  <= shift_result_in;
        // L >= S in magnitude, so the difference never underflows.
        ADD:   sum_word <= (sign_l == sign_s) ? word_l + aligned : word_l - aligned;
        NORM:  sum_out  <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_add_controller.sv
// Self-checking bench for fp16_add_controller with a behavioural shifter
// and an arithmetic reference model of the truncating fp16 add.
module tb_fp16_add_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_in = '0, b_in = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] sum_out;
  logic [15:0] shift_data, shift_result;
  logic [7:0]  shift_amount;
  logic        shift_dir;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign shift_result = shift_dir ? (shift_data >> shift_amount) : (shift_data << shift_amount);

  fp16_add_controller #(.WIDTH(16), .AMOUNT_WIDTH(8)) dut (
    .clock_in         (clk),
    .reset_in         (rst),
    .a_in             (a_in),
    .b_in             (b_in),
    .in_valid_in      (in_valid),
    .in_ready_out     (in_ready),
    .sum_out          (sum_out),
    .out_valid_out    (out_valid),
    .out_ready_in     (out_ready),
    .shift_data_out   (shift_data),
    .shift_amount_out (shift_amount),
    .shift_dir_out    (shift_dir),
    .shift_result_in  (shift_result)
  );

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] l, s;
    logic an, bn, ai, bi;
    int ml, ms, r, e;
    an = (a[14:10] == 5'd31) && (a[9:0] != 0);
    bn = (b[14:10] == 5'd31) && (b[9:0] != 0);
    ai = (a[14:10] == 5'd31) && (a[9:0] == 0);
    bi = (b[14:10] == 5'd31) && (b[9:0] == 0);
    if (an || bn || (ai && bi && a[15] != b[15])) return 16'h7E00;
    if (ai) return a;
    if (bi) return b;
    if (a[14:0] >= b[14:0]) begin l = a; s = b; end
    else begin l = b; s = a; end
    ml = (l[14:10] == 0) ? 0 : (1024 + int'(l[9:0])) * 16;
    ms = (s[14:10] == 0) ? 0 : (1024 + int'(s[9:0])) * 16;
    ms = ms >> (int'(l[14:10]) - int'(s[14:10]));
    r  = (l[15] == s[15]) ? ml + ms : ml - ms;
    if (r == 0) return 16'h0000;
    e = int'(l[14:10]);
    while (r >= 32768) begin r = r / 2; e++; end
    while (r < 16384) begin r = r * 2; e--; end
    if (e >= 31) return {l[15], 5'h1F, 10'h0};
    if (e <= 0)  return {l[15], 15'h0};
    return {l[15], 5'(e), 10'((r / 16) % 1024)};
  endfunction

  function automatic int ref_align(input logic [15:0] a, input logic [15:0] b);
    if (a[14:0] >= b[14:0]) return int'(a[14:10]) - int'(b[14:10]);
    return int'(b[14:10]) - int'(a[14:10]);
  endfunction

  // Drives one operand pair and records what the DUT shows in each cycle after accept.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic hold_valid,
                        output logic [15:0] sum, output int lat,
                        output logic [7:0] al_amt, output logic al_dir,
                        output logic [7:0] nm_amt, output logic nm_dir,
                        output logic [15:0] nm_data, output logic rdy_done);
    int guard;
    sum = 16'hDEAD; lat = 99; al_amt = 8'hFF; al_dir = 1'b0;
    nm_amt = 8'hFF; nm_dir = 1'b1; nm_data = 16'hFFFF; rdy_done = 1'b1;
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin al_amt = shift_amount; al_dir = shift_dir; end
      if (c == 3) begin nm_amt = shift_amount; nm_dir = shift_dir; nm_data = shift_data; end
      if (out_valid) begin lat = c; sum = sum_out; rdy_done = in_ready; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, sum_out, shift_data, shift_amount, shift_dir} !== {1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%h sd=%h sa=%h dir=%b, want rdy=1 vld=0 rest 0",
               in_ready, out_valid, sum_out, shift_data, shift_amount, shift_dir);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va [7] = '{16'h3C00, 16'h3C00, 16'h3C01, 16'h7800, 16'h7000, 16'h7BFF, 16'h7C00};
    logic [15:0] vb [7] = '{16'h3C00, 16'hBC00, 16'hBC00, 16'h0400, 16'h3C00, 16'h7BFF, 16'hFC00};
    logic [15:0] vs [7] = '{16'h4000, 16'h0000, 16'h1400, 16'h7800, 16'h7000, 16'h7C00, 16'h7E00};
    logic [7:0]  aa [7] = '{8'd0, 8'd0, 8'd0, 8'd29, 8'd13, 8'd0, 8'd0};
    logic        nd [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  na [7] = '{8'd1, 8'd0, 8'd10, 8'd0, 8'd0, 8'd1, 8'd0};
    logic [15:0] sum, nm_data; int lat;
    logic [7:0] al_amt, nm_amt; logic al_dir, nm_dir, rdy;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], 1'b0, sum, lat, al_amt, al_dir, nm_amt, nm_dir, nm_data, rdy);
      vectors++;
      if (sum !== vs[i]) begin
        miscompares++;
        $display("FAIL directed_sum %h+%h: got %h want %h", va[i], vb[i], sum, vs[i]);
      end
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("FAIL directed_latency %h+%h: got %0d want 4", va[i], vb[i], lat);
      end
      vectors++;
      if ({al_dir, al_amt} !== {1'b1, aa[i]}) begin
        miscompares++;
        $display("FAIL directed_align %h+%h: dir=%b amt=%0d want dir=1 amt=%0d", va[i], vb[i], al_dir, al_amt, aa[i]);
      end
      vectors++;
      if ({nm_dir, nm_amt} !== {nd[i], na[i]}) begin
        miscompares++;
        $display("FAIL directed_norm %h+%h: dir=%b amt=%0d want dir=%b amt=%0d", va[i], vb[i], nm_dir, nm_amt, nd[i], na[i]);
      end
      if (vs[i] == 16'h0000) begin
        vectors++;
        if (nm_data !== 16'h0) begin
          miscompares++;
          $display("FAIL cancel_no_shift: norm data %h want 0000", nm_data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held; int guard; int bad;
    @(negedge clk);
    a_in = 16'h4000; b_in = 16'h3C00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!out_valid && guard < 20);
    held = sum_out;
    vectors++;
    if (held !== 16'h4200) begin
      miscompares++;
      $display("FAIL bp_sum: got %h want 4200", held);
    end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (sum_out !== 16'h4200 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0 (sum=%h rdy=%b vld=%b)", bad, sum_out, in_ready, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sum, nm_data, a, b; int lat;
    logic [7:0] al_amt, nm_amt; logic al_dir, nm_dir, rdy;
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      run_op(a, b, 1'b1, sum, lat, al_amt, al_dir, nm_amt, nm_dir, nm_data, rdy);
      vectors++;
      if (sum !== ref_add(a, b) || lat !== 4) begin
        miscompares++;
        $display("FAIL b2b_sum %h+%h: got %h lat %0d want %h lat 4", a, b, sum, lat, ref_add(a, b));
      end
      vectors++;
      if (rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_ready_in_done: in_ready=%b want 0", rdy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] sum, nm_data, a, b, exp_sum; int lat;
    logic [7:0] al_amt, nm_amt; logic al_dir, nm_dir, rdy;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b[14:0] = a[14:0] ^ 15'($urandom_range(0, 7));
      exp_sum = ref_add(a, b);
      run_op(a, b, 1'b0, sum, lat, al_amt, al_dir, nm_amt, nm_dir, nm_data, rdy);
      vectors++;
      if (sum !== exp_sum) begin
        miscompares++;
        $display("FAIL random_sum %h+%h: got %h want %h", a, b, sum, exp_sum);
      end
      vectors++;
      if (lat !== 4 || int'(al_amt) != ref_align(a, b)) begin
        miscompares++;
        $display("FAIL random_timing %h+%h: lat %0d align %0d want lat 4 align %0d", a, b, lat, al_amt, ref_align(a, b));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    a_in = 16'h3C00; b_in = 16'h4000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({shift_dir, shift_amount, shift_data} !== {1'b1, 8'd1, 16'h4000}) begin
      miscompares++;
      $display("FAIL rst_align_ports: dir=%b amt=%0d data=%h want 1 1 4000", shift_dir, shift_amount, shift_data);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, sum_out, shift_data, shift_amount, shift_dir} !== {1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid_state: rdy=%b vld=%b sum=%h sd=%h sa=%h dir=%b want rdy=1 rest 0",
               in_ready, out_valid, sum_out, shift_data, shift_amount, shift_dir);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_no_result: out_valid seen %0d cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp16_add_controller.md
Name: fp16_add_controller

Overview:
- Multi-cycle IEEE-754 half-precision adder/sequencer.
- Owns one external shared barrel shifter and time-multiplexes it between two uses:
  - exponent alignment, as a right shift;
  - post-add normalization, as a left shift, or a right shift by 1 on carry-out.
- Accepts operand pairs over a valid/ready handshake and returns a truncated (round-toward-zero) sum.
- Sits between the operand source and the result consumer in the floating-point adder.

Parameters:
- WIDTH, 16: shifter data width; only 16 is supported (fixes the extended-significand layout).
- AMOUNT_WIDTH, 8: shifter amount width; must match the shifter instance.

Ports:
- clock_in  input  1  system clock; all state changes on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- a_in  input  16  operand A, half-precision {sign, exp[4:0], frac[9:0]}.
- b_in  input  16  operand B, same format.
- in_valid_in  input  1  operand pair valid.
- in_ready_out  output  1  controller can accept operands.
- sum_out  output  16  result, half-precision.
- out_valid_out  output  1  sum_out valid.
- out_ready_in  input  1  consumer accepts the result.
- shift_data_out  output  WIDTH  data to the shared shifter.
- shift_amount_out  output  AMOUNT_WIDTH  shift amount to the shifter.
- shift_dir_out  output  1  1 = right shift, 0 = left shift.
- shift_result_in  input  WIDTH  combinational shifter result, same cycle.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - During and after reset: FSM = IDLE, in_ready_out = 1, out_valid_out = 0, sum_out = 0, shift_data_out = 0, shift_amount_out = 0, shift_dir_out = 0.
  - Reset in any state aborts the operation with no output produced.
- Extended significand word (16 bits): bit 15 = carry, bit 14 = hidden 1, bits 13:4 = frac, bits 3:0 = guard.
  - An operand with exp = 0 has its significand forced to 0 (denormals flushed to zero).
- FSM, fixed latency: out_valid_out rises exactly 4 cycles after the accept edge.
  - IDLE:
    - in_ready_out = 1.
    - Accept when in_valid_in & in_ready_out.
    - Register the operands, swapped so operand L has the larger magnitude: compare exp first, then frac.
    - Go to ALIGN.
  - ALIGN:
    - Drive the shifter: data = S's word, amount = expL - expS (zero-extended), dir = 1.
    - Amounts of 16 or more yield 0 (the shifter clears when amount > WIDTH; 16 shifts everything out).
    - Latch shift_result_in. Go to ADD.
  - ADD:
    - Same signs: wordL + aligned. Different signs: wordL - aligned (never negative, by construction).
    - Sign = signL. Go to NORM.
  - NORM:
    - Carry (bit 15 = 1): shift right by 1, exp = expL + 1.
    - Otherwise: k = leading zeros of bits 14:0; shift left by k, exp = expL - k.
    - Sum = 0: skip the shift, result = +0 (0x0000).
    - Go to DONE.
  - DONE:
    - out_valid_out = 1; sum_out = {sign, exp, word[13:4]}.
    - sum_out is held stable until out_ready_in = 1, then return to IDLE with in_ready_out = 1 on the next cycle.
    - No new accept occurs in the same cycle as the result handshake.
- Boundary handling:
  - Exponent reaches 31 after normalize: result = {sign, 5'h1F, 0} (infinity).
  - Exponent reaches 0 or below: result = {sign, 0, 0} (flush to signed zero).
- Specials: either input with exp = 31 still traverses every state (latency unchanged); sum_out is overridden.
  - Any NaN, or +inf + -inf: result = 0x7E00.
  - Otherwise: result = the infinity operand.
- Shifter ports are driven only in ALIGN and NORM; in all other states they are 0.
- in_ready_out = 0 in every state except IDLE.

Decomposition:
- Package fp16_pkg:
  - state enum (IDLE, ALIGN, ADD, NORM, DONE);
  - EXP_WIDTH = 5, FRAC_WIDTH = 10, EXP_MAX = 31;
  - the extended-word bit-position constants;
  - QNAN = 16'h7E00.
- One natural sub-module: leading_zero_counter (15-bit input, 4-bit count), purely combinational.
- The barrel shifter stays external and is connected at the parent.

Test Plan:
- Basic add, latency check: 0x3C00 + 0x3C00, single accept -> sum_out = 0x4000 with out_valid_out exactly 4 cycles after accept; shifter dir = 1, amount = 0 in ALIGN.
- Cancellation to zero: 0x3C00 + 0xBC00 -> 0x0000 (+0); no left shift issued in NORM.
- Deep cancellation: 0x3C01 + 0xBC00 -> 0x1400; NORM drives dir = 0, amount = 10.
- Alignment clamp and truncation:
  - 0x7800 + 0x0400 -> 0x7800 (ALIGN amount = 29, shifter returns 0);
  - 0x7000 + 0x3C00 -> 0x7000 (truncated).
- Overflow and specials:
  - 0x7BFF + 0x7BFF -> 0x7C00;
  - 0x7C00 + 0xFC00 -> 0x7E00.
- Backpressure and reset:
  - Hold out_ready_in = 0 for 3 cycles in DONE -> sum_out stable, in_ready_out = 0.
  - Assert reset_in during ALIGN -> next cycle IDLE, out_valid_out = 0, shifter ports 0, and no result emitted.
